// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions: BRESP encodings and default sizing
// for the write-response routing path.
package axi_ic_pkg;
    localparam int RESP_W    = 2;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [RESP_W-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } bresp_e;
endpackage

// File: rtl/sync_order_fifo.sv
// Small synchronous FIFO recording which master issued each outstanding AW.
// Push while full and pop while empty are ignored; pointers wrap naturally.
module sync_order_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wptr, rptr;
    logic                    push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop_ok)
                rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/write_resp_demux.sv
// Routes slave B responses back to the master that issued the matching AW,
// in issue order, through a single output holding register.
module write_resp_demux #(
    parameter int DEPTH  = axi_ic_pkg::DEPTH_DEF,
    parameter int RESP_W = axi_ic_pkg::RESP_W
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      aw_push,
    input  logic                      aw_sel,
    output logic                      aw_full,
    input  logic                      S_BVALID,
    input  logic [RESP_W-1:0]         S_BRESP,
    output logic                      S_BREADY,
    output logic                      M0_BVALID,
    output logic [RESP_W-1:0]         M0_BRESP,
    input  logic                      M0_BREADY,
    output logic                      M1_BVALID,
    output logic [RESP_W-1:0]         M1_BRESP,
    input  logic                      M1_BREADY,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      ovf_err
);
    logic              hold_valid, hold_dst;
    logic [RESP_W-1:0] hold_resp;
    logic              head, fifo_empty, drain, cap;

    // Only the addressed master's BREADY can release the holding register.
    assign drain    = hold_valid && (hold_dst ? M1_BREADY : M0_BREADY);
    assign S_BREADY = !fifo_empty && (!hold_valid || drain);
    assign cap      = S_BVALID && S_BREADY;

    sync_order_fifo #(.DEPTH(DEPTH), .W(1)) u_order (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (aw_push),
        .din   (aw_sel),
        .pop   (cap),
        .dout  (head),
        .full  (aw_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    assign M0_BVALID = hold_valid && !hold_dst;
    assign M1_BVALID = hold_valid &&  hold_dst;
    assign M0_BRESP  = M0_BVALID ? hold_resp : '0;
    assign M1_BRESP  = M1_BVALID ? hold_resp : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hold_valid <= 1'b0;
            hold_dst   <= 1'b0;
            hold_resp  <= '0;
            ovf_err    <= 1'b0;
        end else begin
            if (aw_push && aw_full)
                ovf_err <= 1'b1;
            if (cap) begin
                hold_valid <= 1'b1;
                hold_dst   <= head;
                hold_resp  <= S_BRESP;
            end else if (drain) begin
                hold_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_write_resp_demux.sv
// Bench for write_resp_demux: directed scenarios plus a randomized run scored
// against a queue-based model of in-order response routing.
module tb_write_resp_demux;
    localparam int DEPTH = 4;
    localparam int RW    = 2;
    localparam int CW    = 3;

    logic          ACLK = 1'b0, ARESETN = 1'b0;
    logic          aw_push = 1'b0, aw_sel = 1'b0, aw_full;
    logic          S_BVALID = 1'b0, S_BREADY;
    logic [RW-1:0] S_BRESP = '0;
    logic          M0_BVALID, M1_BVALID;
    logic          M0_BREADY = 1'b0, M1_BREADY = 1'b0;
    logic [RW-1:0] M0_BRESP, M1_BRESP;
    logic [CW-1:0] outstanding;
    logic          ovf_err;

    int errors = 0, checks = 0;

    write_resp_demux #(.DEPTH(DEPTH), .RESP_W(RW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .aw_push(aw_push), .aw_sel(aw_sel), .aw_full(aw_full),
        .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .S_BREADY(S_BREADY),
        .M0_BVALID(M0_BVALID), .M0_BRESP(M0_BRESP), .M0_BREADY(M0_BREADY),
        .M1_BVALID(M1_BVALID), .M1_BRESP(M1_BRESP), .M1_BREADY(M1_BREADY),
        .outstanding(outstanding), .ovf_err(ovf_err)
    );

    always #5 ACLK = ~ACLK;

    // Reference model: pending originators in issue order, one held response.
    bit          mq[$];
    bit          mhv, mhd, movf;
    logic [1:0]  mhr;

    task automatic mdl_reset();
        mq.delete();
        mhv = 0; mhd = 0; mhr = '0; movf = 0;
    endtask

    function automatic bit f_drain();
        return mhv && (mhd ? M1_BREADY : M0_BREADY);
    endfunction

    function automatic bit f_sready();
        return (mq.size() != 0) && (!mhv || f_drain());
    endfunction

    // Advance one clock: model sees the same inputs the DUT samples.
    task automatic cyc();
        bit dr, cap, pok, ov;
        dr  = f_drain();
        cap = S_BVALID && f_sready();
        pok = aw_push && (mq.size() < DEPTH);
        ov  = aw_push && (mq.size() == DEPTH);
        @(posedge ACLK);
        if (ov) movf = 1;
        if (cap) begin
            mhd = mq.pop_front();
            mhr = S_BRESP;
            mhv = 1;
        end else if (dr) begin
            mhv = 0;
        end
        if (pok) mq.push_back(aw_sel);
        #1;
    endtask

    task automatic idle();
        aw_push = 0; S_BVALID = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({aw_full, outstanding, ovf_err, S_BREADY, M0_BVALID, M1_BVALID, M0_BRESP, M1_BRESP} !== '0)
            begin errors++; $display("FAIL reset_outputs got=%b exp=0",
                {aw_full, outstanding, ovf_err, S_BREADY, M0_BVALID, M1_BVALID, M0_BRESP, M1_BRESP}); end
        repeat (2) @(posedge ACLK);
        #2 ARESETN = 1;
        mdl_reset();
    endtask

    task automatic test_single();
        M0_BREADY = 1; M1_BREADY = 1;
        aw_push = 1; aw_sel = 0;
        cyc();
        aw_push = 0;
        checks++;
        if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding1 got=%0d exp=1", outstanding); end
        S_BVALID = 1; S_BRESP = 2'b00; #1;
        checks++;
        if (S_BREADY !== 1'b1) begin errors++; $display("FAIL single_sready got=%b exp=1", S_BREADY); end
        cyc();
        S_BVALID = 0; #1;
        checks++;
        if ({M0_BVALID, M0_BRESP, M1_BVALID, outstanding} !== {1'b1, 2'b00, 1'b0, 3'd0})
            begin errors++; $display("FAIL single_deliver got=%b exp=%b",
                {M0_BVALID, M0_BRESP, M1_BVALID, outstanding}, {1'b1, 2'b00, 1'b0, 3'd0}); end
        cyc();
        checks++;
        if (M0_BVALID !== 1'b0) begin errors++; $display("FAIL single_clear got=%b exp=0", M0_BVALID); end
    endtask

    task automatic test_back_to_back();
        bit         sels[3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0] rs[3]   = '{2'b10, 2'b00, 2'b11};
        M0_BREADY = 1; M1_BREADY = 1;
        for (int i = 0; i < 3; i++) begin
            aw_push = 1; aw_sel = sels[i]; cyc();
        end
        aw_push = 0;
        for (int i = 0; i < 3; i++) begin
            S_BVALID = 1; S_BRESP = rs[i]; #1;
            checks++;
            if (S_BREADY !== 1'b1) begin errors++; $display("FAIL b2b_sready[%0d] got=%b exp=1", i, S_BREADY); end
            cyc();
            checks++;
            if (sels[i] ? ({M1_BVALID, M1_BRESP, M0_BVALID} !== {1'b1, rs[i], 1'b0})
                        : ({M0_BVALID, M0_BRESP, M1_BVALID} !== {1'b1, rs[i], 1'b0}))
                begin errors++; $display("FAIL b2b_route[%0d] got m0=%b/%b m1=%b/%b exp sel=%0d resp=%b",
                    i, M0_BVALID, M0_BRESP, M1_BVALID, M1_BRESP, sels[i], rs[i]); end
        end
        S_BVALID = 0;
        cyc();
    endtask

    task automatic test_backpressure();
        M0_BREADY = 1; M1_BREADY = 0;
        aw_push = 1; aw_sel = 1; cyc(); cyc();
        aw_push = 0;
        S_BVALID = 1; S_BRESP = 2'b10; #1;
        checks++;
        if (S_BREADY !== 1'b1) begin errors++; $display("FAIL bp_first_sready got=%b exp=1", S_BREADY); end
        cyc();
        S_BRESP = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({S_BREADY, M1_BVALID, M1_BRESP, outstanding} !== {1'b0, 1'b1, 2'b10, 3'd1})
                begin errors++; $display("FAIL bp_stall[%0d] got=%b exp=%b", i,
                    {S_BREADY, M1_BVALID, M1_BRESP, outstanding}, {1'b0, 1'b1, 2'b10, 3'd1}); end
            if (i < 3) cyc();
        end
        M1_BREADY = 1; #1;
        checks++;
        if (S_BREADY !== 1'b1) begin errors++; $display("FAIL bp_release_sready got=%b exp=1", S_BREADY); end
        cyc();
        S_BVALID = 0;
        checks++;
        if ({M1_BVALID, M1_BRESP, outstanding} !== {1'b1, 2'b01, 3'd0})
            begin errors++; $display("FAIL bp_second got=%b exp=%b",
                {M1_BVALID, M1_BRESP, outstanding}, {1'b1, 2'b01, 3'd0}); end
        cyc();
    endtask

    task automatic test_overflow();
        M0_BREADY = 1; M1_BREADY = 1;
        for (int i = 0; i < 4; i++) begin
            aw_push = 1; aw_sel = 1'($urandom); cyc();
        end
        aw_push = 0;
        checks++;
        if ({aw_full, outstanding, ovf_err} !== {1'b1, 3'd4, 1'b0})
            begin errors++; $display("FAIL ovf_full got=%b exp=%b", {aw_full, outstanding, ovf_err}, {1'b1, 3'd4, 1'b0}); end
        aw_push = 1; cyc();
        aw_push = 0;
        checks++;
        if ({ovf_err, outstanding} !== {1'b1, 3'd4})
            begin errors++; $display("FAIL ovf_flag got=%b exp=%b", {ovf_err, outstanding}, {1'b1, 3'd4}); end
        // Push into a full FIFO is dropped even when a pop happens the same cycle.
        aw_push = 1; S_BVALID = 1; S_BRESP = 2'($urandom); cyc();
        checks++;
        if ({outstanding, ovf_err, aw_full} !== {3'd3, 1'b1, 1'b0})
            begin errors++; $display("FAIL ovf_push_pop_full got=%b exp=%b", {outstanding, ovf_err, aw_full}, {3'd3, 1'b1, 1'b0}); end
        S_BRESP = 2'($urandom); cyc();
        checks++;
        if (outstanding !== 3'd3) begin errors++; $display("FAIL push_pop_same got=%0d exp=3", outstanding); end
        aw_push = 0;
        for (int i = 0; i < 3; i++) begin
            S_BRESP = 2'($urandom); cyc();
        end
        S_BVALID = 0;
        checks++;
        if ({outstanding, M0_BVALID, M0_BRESP, M1_BVALID, M1_BRESP} !==
            {3'd0, mhv && !mhd, (mhv && !mhd) ? mhr : 2'b00, mhv && mhd, (mhv && mhd) ? mhr : 2'b00})
            begin errors++; $display("FAIL ovf_drain got=%b model_q=%0d hv=%b hd=%b hr=%b",
                {outstanding, M0_BVALID, M0_BRESP, M1_BVALID, M1_BRESP}, mq.size(), mhv, mhd, mhr); end
        cyc();
    endtask

    task automatic test_stall_empty();
        M0_BREADY = 1; M1_BREADY = 1;
        S_BVALID = 1; S_BRESP = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({S_BREADY, M0_BVALID, M1_BVALID} !== 3'b000)
                begin errors++; $display("FAIL stall_empty[%0d] got=%b exp=000", i, {S_BREADY, M0_BVALID, M1_BVALID}); end
            cyc();
        end
        aw_push = 1; aw_sel = 0; #1;
        checks++;
        if (S_BREADY !== 1'b0) begin errors++; $display("FAIL stall_push_cycle got=%b exp=0", S_BREADY); end
        cyc();
        aw_push = 0; #1;
        checks++;
        if (S_BREADY !== 1'b1) begin errors++; $display("FAIL stall_after_push got=%b exp=1", S_BREADY); end
        cyc();
        S_BVALID = 0;
        checks++;
        if ({M0_BVALID, M0_BRESP, ovf_err} !== {1'b1, 2'b11, movf})
            begin errors++; $display("FAIL stall_capture got=%b exp=%b", {M0_BVALID, M0_BRESP, ovf_err}, {1'b1, 2'b11, movf}); end
        cyc();
    endtask

    task automatic test_random();
        bit e0, e1;
        for (int n = 0; n < 400; n++) begin
            aw_push   = ($urandom_range(0, 2) == 0);
            aw_sel    = 1'($urandom);
            S_BVALID  = 1'($urandom);
            S_BRESP   = 2'($urandom);
            M0_BREADY = ($urandom_range(0, 9) < 7);
            M1_BREADY = ($urandom_range(0, 9) < 7);
            #1;
            e0 = mhv && !mhd;
            e1 = mhv && mhd;
            checks++;
            if ({S_BREADY, aw_full, outstanding, ovf_err, M0_BVALID, M0_BRESP, M1_BVALID, M1_BRESP} !==
                {f_sready(), mq.size() == DEPTH, 3'(mq.size()), movf, e0, e0 ? mhr : 2'b00, e1, e1 ? mhr : 2'b00})
                begin errors++; $display("FAIL random[%0d] got=%b exp=%b", n,
                    {S_BREADY, aw_full, outstanding, ovf_err, M0_BVALID, M0_BRESP, M1_BVALID, M1_BRESP},
                    {f_sready(), mq.size() == DEPTH, 3'(mq.size()), movf, e0, e0 ? mhr : 2'b00, e1, e1 ? mhr : 2'b00}); end
            cyc();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        bit sels[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        M0_BREADY = 1; M1_BREADY = 1; aw_push = 0;
        S_BVALID = 1;
        while (mq.size() != 0 && guard < 20) begin cyc(); guard++; end
        S_BVALID = 0;
        cyc(); cyc();
        checks++;
        if ({outstanding, M0_BVALID, M1_BVALID} !== 5'd0 || guard >= 20)
            begin errors++; $display("FAIL rst_predrain got=%b guard=%0d exp=0", {outstanding, M0_BVALID, M1_BVALID}, guard); end
        M0_BREADY = 0; M1_BREADY = 0;
        for (int i = 0; i < 4; i++) begin aw_push = 1; aw_sel = sels[i]; cyc(); end
        aw_push = 0;
        S_BVALID = 1; S_BRESP = 2'b10; cyc();
        S_BVALID = 0;
        checks++;
        if ({outstanding, M1_BVALID, M1_BRESP} !== {3'd3, 1'b1, 2'b10})
            begin errors++; $display("FAIL rst_precond got=%b exp=%b", {outstanding, M1_BVALID, M1_BRESP}, {3'd3, 1'b1, 2'b10}); end
        #2 ARESETN = 0;
        mdl_reset();
        #1;
        checks++;
        if ({aw_full, outstanding, ovf_err, S_BREADY, M0_BVALID, M1_BVALID, M0_BRESP, M1_BRESP} !== '0)
            begin errors++; $display("FAIL rst_async got=%b exp=0",
                {aw_full, outstanding, ovf_err, S_BREADY, M0_BVALID, M1_BVALID, M0_BRESP, M1_BRESP}); end
        @(posedge ACLK);
        #2 ARESETN = 1;
        aw_push = 1; aw_sel = 1;
        checks++;
        if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_release got=%0d exp=0", outstanding); end
        cyc();
        aw_push = 0;
        checks++;
        if ({outstanding, M1_BVALID} !== {3'd1, 1'b0})
            begin errors++; $display("FAIL rst_first_push got=%b exp=%b", {outstanding, M1_BVALID}, {3'd1, 1'b0}); end
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_stall_empty();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
